imm_gen_stage: RTL and testbench
================================

Name: imm_gen_stage

Overview:
- Registered, handshaked immediate-generation stage for the RISC-V core.
- Sits between fetch and execute; replaces per-format immediate outputs with one XLEN-wide immediate plus a format tag.
- Adds an illegal-encoding flag, XLEN generalisation (32/64), a 2-entry skid buffer with valid/ready back-pressure, and pipeline flush.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64. Immediates sign-extend to XLEN.
- PC_W, XLEN, width of the PC carried alongside the instruction.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush_i  in  1  synchronous flush: drop all buffered entries.
- in_valid  in  1  upstream has an instruction.
- in_ready  out  1  stage can accept; registered (no combinational path from out_ready).
- in_instr  in  32  raw instruction.
- in_pc  in  PC_W  instruction PC.
- out_valid  out  1  head entry valid.
- out_ready  in  1  downstream accepts head.
- out_instr  out  32  head instruction.
- out_pc  out  PC_W  head PC.
- out_imm  out  XLEN  decoded immediate.
- out_fmt  out  3  imm_fmt_t of head.
- out_illegal  out  1  head encoding illegal/unsupported.

Behaviour:
- Reset (async assert, sync-released usage): count=0, out_valid=0, in_ready=1, out_imm=0, out_fmt=FMT_NONE, out_illegal=0, out_instr=0, out_pc=0.
- Decode happens on the input side. Imm, fmt and illegal are computed from in_instr and stored with the entry. Latency is 1 cycle from accept to out_valid when the buffer is empty.
- Opcode map (sign bit instr[31], extended to XLEN):
  - 0010011 OP-IMM, 0000011 LOAD, 1100111 JALR -> FMT_I, instr[31:20].
  - 0100011 STORE -> FMT_S, {instr[31:25],instr[11:7]}.
  - 1100011 BRANCH -> FMT_B, {instr[31],instr[7],instr[30:25],instr[11:8],0}.
  - 0110111 LUI, 0010111 AUIPC -> FMT_U, {instr[31:12],12'b0}, sign-extended above bit 31 when XLEN=64.
  - 1101111 JAL -> FMT_J, {instr[31],instr[19:12],instr[20],instr[30:21],0}.
  - 0110011 OP -> FMT_R, imm 0.
  - Any other opcode -> FMT_NONE, imm 0, illegal=1.
- Illegal extras:
  - JALR with funct3!=000.
  - OP-IMM shift (funct3 001/101) with instr[25]=1 when XLEN=32.
  - instr[1:0]!=11 (compressed not supported) -> illegal=1, fmt NONE, imm 0.
- Buffer: 2 entries, states EMPTY(0), ONE(1), FULL(2).
  - push = in_valid & in_ready; pop = out_valid & out_ready.
  - EMPTY: push -> ONE.
  - ONE: push&!pop -> FULL; pop&!push -> EMPTY; push&pop -> ONE (new entry becomes head).
  - FULL: pop -> ONE; push is impossible since in_ready=0.
  - in_ready = (count!=2), registered from next count.
  - out_valid = (count!=0).
  - FIFO order is strictly preserved.
- Head outputs hold stable while out_valid & !out_ready.
- flush_i has priority over push and pop: next count=0 and out_valid=0 next cycle. A push in the flush cycle is dropped; in_ready=1 after the flush.
- Async reset mid-operation discards all entries immediately.

Decomposition:
- Package imm_gen_pkg holds:
  - imm_fmt_t enum (3 bits): FMT_NONE=0, FMT_I=1, FMT_S=2, FMT_B=3, FMT_U=4, FMT_J=5, FMT_R=6.
  - Opcode localparams: OPC_OPIMM, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_OP.
  - Struct imm_entry_t {instr, pc, imm, fmt, illegal}.
- Sub-module imm_decode: combinational, parametrised by XLEN; instr -> imm, fmt, illegal. imm_gen_stage instantiates it plus the 2-entry buffer and control.

Test Plan:
- XLEN=32, out_ready=1; push 0xFFF00093 (addi -1), 0xFE112E23 (sw -4), 0xFE000CE3 (beq -8), 0x123452B7 (lui), 0x001000EF (jal +2048) -> one cycle later each: imm 0xFFFFFFFF/I, 0xFFFFFFFC/S, 0xFFFFFFF8/B, 0x12345000/U, 0x00000800/J; illegal=0.
- XLEN=64: push 0x800002B7 (lui) -> out_imm 0xFFFFFFFF80000000, FMT_U.
- Illegal cases:
  - Opcode 0x0000007F -> fmt NONE, imm 0, illegal=1.
  - JALR with funct3=001 -> illegal=1, fmt I.
  - slli with instr[25]=1 at XLEN=32 -> illegal=1.
  - 0x00000001 -> illegal=1.
- Back-pressure: out_ready=0, in_valid held with 3 distinct PCs -> in_ready low after 2 accepts and head stable; raise out_ready -> PCs emerge in order with no loss or duplication.
- Flush with count=2 and a simultaneous push -> next cycle out_valid=0, in_ready=1, dropped instruction never appears.
- Assert rst_n=0 mid-stream with count=1 -> out_valid falls without a clock edge, and all outputs take their reset values.

Source files
------------

// File: rtl/imm_gen_pkg.sv
// Shared types and encodings for the immediate-generation stage.
package imm_gen_pkg;

  // Immediate format tag carried with every decoded instruction.
  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_R    = 3'd6
  } imm_fmt_t;

  // Major opcodes (instr[6:0]) recognised by the decoder.
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // Storage width for PC and immediate fields; wide enough for XLEN=64.
  localparam int unsigned ENTRY_W = 64;

  // One buffered instruction with its decoded immediate.
  typedef struct packed {
    logic [31:0]        instr;
    logic [ENTRY_W-1:0] pc;
    logic [ENTRY_W-1:0] imm;
    imm_fmt_t           fmt;
    logic               illegal;
  } imm_entry_t;

  // Occupancy of the 2-entry skid buffer.
  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_FULL  = 2'd2
  } buf_state_t;

endpackage

// File: rtl/imm_gen_stage_decode.sv
// Combinational RISC-V immediate decoder: instruction -> immediate, format, illegal flag.
module imm_decode
  import imm_gen_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output imm_fmt_t        fmt,
  output logic            illegal
);

  logic [31:0] imm32;
  logic [2:0]  funct3;

  assign funct3 = instr[14:12];

  // Select the immediate layout by opcode and flag unsupported encodings.
  always_comb begin
    imm32   = '0;
    fmt     = FMT_NONE;
    illegal = 1'b0;
    if (instr[1:0] != 2'b11) begin
      illegal = 1'b1;
    end else begin
      case (instr[6:0])
        OPC_OPIMM, OPC_LOAD, OPC_JALR: begin
          fmt   = FMT_I;
          imm32 = {{20{instr[31]}}, instr[31:20]};
          if ((instr[6:0] == OPC_JALR) && (funct3 != 3'b000)) begin
            illegal = 1'b1;
          end
          if ((instr[6:0] == OPC_OPIMM) && ((funct3 == 3'b001) || (funct3 == 3'b101))
              && instr[25] && (XLEN == 32)) begin
            illegal = 1'b1;
          end
        end
        OPC_STORE: begin
          fmt   = FMT_S;
          imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        end
        OPC_BRANCH: begin
          fmt   = FMT_B;
          imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        end
        OPC_LUI, OPC_AUIPC: begin
          fmt   = FMT_U;
          imm32 = {instr[31:12], 12'b0};
        end
        OPC_JAL: begin
          fmt   = FMT_J;
          imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
        end
        OPC_OP: begin
          fmt = FMT_R;
        end
        default: begin
          illegal = 1'b1;
        end
      endcase
    end
  end

  // Every format is already sign-extended to 32 bits; widen to XLEN by sign.
  assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/imm_gen_stage.sv
// Registered immediate-generation stage: decode on input, 2-entry skid buffer, flush.
module imm_gen_stage
  import imm_gen_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned PC_W = XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush_i,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic [PC_W-1:0] out_pc,
  output logic [XLEN-1:0] out_imm,
  output imm_fmt_t        out_fmt,
  output logic            out_illegal
);

  logic [XLEN-1:0] dec_imm;
  imm_fmt_t        dec_fmt;
  logic            dec_illegal;

  imm_decode #(.XLEN(XLEN)) u_decode (
    .instr   (in_instr),
    .imm     (dec_imm),
    .fmt     (dec_fmt),
    .illegal (dec_illegal)
  );

  buf_state_t state_q, state_d;
  imm_entry_t new_ent, ent0, ent1;
  logic       push, pop;
  logic       load0, load1, shift;

  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign out_valid = (state_q != BUF_EMPTY);

  // Package the decoded instruction into a buffer entry.
  always_comb begin
    new_ent         = '0;
    new_ent.instr   = in_instr;
    new_ent.pc      = ENTRY_W'(in_pc);
    new_ent.imm     = ENTRY_W'(dec_imm);
    new_ent.fmt     = dec_fmt;
    new_ent.illegal = dec_illegal;
  end

  // Next occupancy and entry-move controls; ent0 is always the head.
  always_comb begin
    state_d = state_q;
    load0   = 1'b0;
    load1   = 1'b0;
    shift   = 1'b0;
    if (flush_i) begin
      state_d = BUF_EMPTY;
    end else begin
      case (state_q)
        BUF_EMPTY: begin
          if (push) begin
            state_d = BUF_ONE;
            load0   = 1'b1;
          end
        end
        BUF_ONE: begin
          if (push && pop) begin
            load0 = 1'b1;
          end else if (push) begin
            state_d = BUF_FULL;
            load1   = 1'b1;
          end else if (pop) begin
            state_d = BUF_EMPTY;
          end
        end
        BUF_FULL: begin
          if (pop) begin
            state_d = BUF_ONE;
            shift   = 1'b1;
          end
        end
        default: begin
          state_d = BUF_EMPTY;
        end
      endcase
    end
  end

  // Occupancy register; in_ready is registered from the next occupancy so it
  // never depends combinationally on out_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= BUF_EMPTY;
      in_ready <= 1'b1;
    end else begin
      state_q  <= state_d;
      in_ready <= (state_d != BUF_FULL);
    end
  end

  // Entry storage: head loads directly or takes the second slot on a pop from FULL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent0 <= '0;
      ent1 <= '0;
    end else begin
      if (load0) begin
        ent0 <= new_ent;
      end else if (shift) begin
        ent0 <= ent1;
      end
      if (load1) begin
        ent1 <= new_ent;
      end
    end
  end

  assign out_instr   = ent0.instr;
  assign out_pc      = ent0.pc[PC_W-1:0];
  assign out_imm     = ent0.imm[XLEN-1:0];
  assign out_fmt     = ent0.fmt;
  assign out_illegal = ent0.illegal;

  // Upper storage bits are unused when XLEN/PC_W are below the storage width.
  logic unused_hi;
  assign unused_hi = ^{ent0.pc, ent0.imm};

endmodule

// File: tb/tb_imm_gen_stage.sv
// Self-checking bench for imm_gen_stage: XLEN=32 and XLEN=64 instances share stimulus.
module tb_imm_gen_stage;
  import imm_gen_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush_i = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_instr = '0;
  logic [31:0] in_pc = '0;
  logic [31:0] pc_hi = '0;

  logic        in_ready, out_valid, out_illegal;
  logic [31:0] out_instr, out_pc, out_imm;
  imm_fmt_t    out_fmt;

  logic        w_in_ready, w_out_valid, w_out_illegal;
  logic [31:0] w_out_instr;
  logic [63:0] w_out_pc, w_out_imm;
  imm_fmt_t    w_out_fmt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] instr;
    logic [63:0] pc;
    logic [63:0] imm32;
    logic [2:0]  fmt;
    logic        ill32;
    logic [63:0] imm64;
    logic        ill64;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  imm_gen_stage #(.XLEN(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .out_imm(out_imm), .out_fmt(out_fmt), .out_illegal(out_illegal)
  );

  imm_gen_stage #(.XLEN(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .in_valid(in_valid), .in_ready(w_in_ready), .in_instr(in_instr), .in_pc({pc_hi, in_pc}),
    .out_valid(w_out_valid), .out_ready(out_ready), .out_instr(w_out_instr), .out_pc(w_out_pc),
    .out_imm(w_out_imm), .out_fmt(w_out_fmt), .out_illegal(w_out_illegal)
  );

  // Reference decode: field values as signed integers, then truncated to XLEN.
  function automatic void ref_decode(input logic [31:0] ins, input int xlen,
                                     output logic [63:0] imm, output logic [2:0] fmt,
                                     output logic ill);
    longint v;
    v = 0; fmt = 3'd0; ill = 1'b0;
    if (ins[1:0] != 2'b11) begin
      ill = 1'b1;
    end else begin
      case (ins[6:0])
        7'h13, 7'h03, 7'h67: begin
          fmt = 3'd1;
          v = longint'(ins[31:20]);
          if (v >= 2048) v = v - 4096;
          if (ins[6:0] == 7'h67 && ins[14:12] != 0) ill = 1'b1;
          if (ins[6:0] == 7'h13 && (ins[14:12] == 1 || ins[14:12] == 5) && ins[25] && xlen == 32)
            ill = 1'b1;
        end
        7'h23: begin
          fmt = 3'd2;
          v = longint'(ins[31:25]) * 32 + longint'(ins[11:7]);
          if (v >= 2048) v = v - 4096;
        end
        7'h63: begin
          fmt = 3'd3;
          v = longint'(ins[31]) * 4096 + longint'(ins[7]) * 2048
            + longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2;
          if (v >= 4096) v = v - 8192;
        end
        7'h37, 7'h17: begin
          fmt = 3'd4;
          v = longint'(ins[31:12]) * 4096;
          if (v >= 64'sh8000_0000) v = v - 64'sh1_0000_0000;
        end
        7'h6F: begin
          fmt = 3'd5;
          v = longint'(ins[31]) * (1 << 20) + longint'(ins[19:12]) * 4096
            + longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2;
          if (v >= (1 << 20)) v = v - (1 << 21);
        end
        7'h33: fmt = 3'd6;
        default: ill = 1'b1;
      endcase
    end
    imm = 64'(v);
    if (xlen == 32) imm = {32'h0, imm[31:0]};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [6:0]  opcs [9];
    opcs = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33};
    r = $urandom;
    case ($urandom_range(0, 12))
      9:  ;
      10: begin r[6:0] = 7'h13; r[14:12] = 3'b001; end
      11: begin r[6:0] = 7'h13; r[14:12] = 3'b101; end
      12: r[1:0] = 2'b01;
      default: r[6:0] = opcs[$urandom_range(0, 8)];
    endcase
    return r;
  endfunction

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || w_out_valid !== 1'b0)
      begin errors++; $display("FAIL reset_valid got %b/%b want 0", out_valid, w_out_valid); end
    checks++;
    if (in_ready !== 1'b1 || w_in_ready !== 1'b1)
      begin errors++; $display("FAIL reset_ready got %b/%b want 1", in_ready, w_in_ready); end
    checks++;
    if (out_imm !== 32'h0 || out_fmt !== FMT_NONE || out_illegal !== 1'b0 ||
        out_instr !== 32'h0 || out_pc !== 32'h0)
      begin errors++; $display("FAIL reset_data got imm %h fmt %0d ill %b instr %h pc %h want zeros",
                               out_imm, out_fmt, out_illegal, out_instr, out_pc); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      begin errors++; $display("FAIL post_reset got valid %b ready %b want 0/1", out_valid, in_ready); end
  endtask

  task automatic test_formats();
    logic [31:0] vi [5];
    logic [31:0] vimm [5];
    logic [2:0]  vfmt [5];
    vi   = '{32'hFFF00093, 32'hFE112E23, 32'hFE000CE3, 32'h123452B7, 32'h001000EF};
    vimm = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFF8, 32'h12345000, 32'h00000800};
    vfmt = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_instr = vi[i]; in_pc = 32'h100 + 32'(i * 4); out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_imm !== vimm[i] || out_fmt !== vfmt[i] || out_illegal !== 1'b0)
        begin errors++; $display("FAIL fmt_%0d got v %b imm %h fmt %0d ill %b want 1 %h %0d 0",
                                 i, out_valid, out_imm, out_fmt, out_illegal, vimm[i], vfmt[i]); end
    end
    @(negedge clk);
  endtask

  task automatic test_xlen64();
    @(negedge clk);
    in_valid = 1'b1; in_instr = 32'h800002B7; in_pc = 32'h1000; pc_hi = 32'hABCD0000; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (w_out_valid !== 1'b1 || w_out_imm !== 64'hFFFFFFFF80000000 || w_out_fmt !== FMT_U)
      begin errors++; $display("FAIL lui64 got v %b imm %h fmt %0d want 1 ffffffff80000000 4",
                               w_out_valid, w_out_imm, w_out_fmt); end
    checks++;
    if (w_out_pc !== 64'hABCD000000001000 || out_imm !== 32'h80000000)
      begin errors++; $display("FAIL pc64_imm32 got pc %h imm32 %h want abcd000000001000 80000000",
                               w_out_pc, out_imm); end
    @(negedge clk);
  endtask

  task automatic test_illegal();
    logic [31:0] vi [4];
    logic [2:0]  vfmt [4];
    logic        vw [4];
    vi   = '{32'h0000007F, 32'h000010E7, 32'h02009093, 32'h00000001};
    vfmt = '{3'd0, 3'd1, 3'd1, 3'd0};
    vw   = '{1'b1, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_instr = vi[i]; out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_illegal !== 1'b1 || out_fmt !== vfmt[i] ||
          (vfmt[i] == 3'd0 && out_imm !== 32'h0))
        begin errors++; $display("FAIL illegal_%0d got v %b ill %b fmt %0d imm %h want 1 1 %0d",
                                 i, out_valid, out_illegal, out_fmt, out_imm, vfmt[i]); end
      checks++;
      if (w_out_illegal !== vw[i])
        begin errors++; $display("FAIL illegal64_%0d got %b want %b", i, w_out_illegal, vw[i]); end
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    logic [31:0] p0, ins [3];
    p0 = $urandom & 32'hFFFFFFF0;
    for (int i = 0; i < 3; i++) ins[i] = rand_instr();
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_instr = ins[0]; in_pc = p0;
    @(negedge clk);
    in_instr = ins[1]; in_pc = p0 + 4;
    @(negedge clk);
    in_instr = ins[2]; in_pc = p0 + 8;
    checks++;
    if (in_ready !== 1'b0 || out_pc !== p0)
      begin errors++; $display("FAIL bp_full got ready %b pc %h want 0 %h", in_ready, out_pc, p0); end
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_pc !== p0 || out_instr !== ins[0])
      begin errors++; $display("FAIL bp_hold got ready %b v %b pc %h want 0 1 %h", in_ready, out_valid, out_pc, p0); end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_pc !== p0 + 4 || out_instr !== ins[1] || in_ready !== 1'b1)
      begin errors++; $display("FAIL bp_order1 got pc %h ready %b want %h 1", out_pc, in_ready, p0 + 4); end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (out_pc !== p0 + 8 || out_instr !== ins[2] || out_valid !== 1'b1)
      begin errors++; $display("FAIL bp_order2 got pc %h v %b want %h 1", out_pc, out_valid, p0 + 8); end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0)
      begin errors++; $display("FAIL bp_drain got valid %b want 0", out_valid); end
  endtask

  task automatic test_flush();
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00000013; in_pc = 32'hA0;
    @(negedge clk);
    in_pc = 32'hA4;
    @(negedge clk);
    flush_i = 1'b1; in_pc = 32'hC0;
    @(negedge clk);
    flush_i = 1'b0; in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      begin errors++; $display("FAIL flush_full got v %b ready %b want 0 1", out_valid, in_ready); end
    in_valid = 1'b1; in_pc = 32'hD0;
    @(negedge clk);
    flush_i = 1'b1; in_pc = 32'hE0;
    @(negedge clk);
    flush_i = 1'b0; in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      begin errors++; $display("FAIL flush_push got v %b ready %b want 0 1", out_valid, in_ready); end
    in_valid = 1'b1; in_pc = 32'hF0;
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'hF0)
      begin errors++; $display("FAIL flush_after got v %b pc %h want 1 f0", out_valid, out_pc); end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0)
      begin errors++; $display("FAIL flush_ghost got v %b pc %h want 0", out_valid, out_pc); end
  endtask

  task automatic test_random_stream(input int n);
    exp_t e;
    q.delete();
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (c < n - 6) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        out_ready = ($urandom_range(0, 3) != 0);
        flush_i   = ($urandom_range(0, 31) == 0);
      end else begin
        in_valid = 1'b0; out_ready = 1'b1; flush_i = 1'b0;
      end
      in_instr = rand_instr(); in_pc = $urandom; pc_hi = $urandom;
      checks++;
      if (out_valid !== (q.size() != 0) || w_out_valid !== (q.size() != 0) ||
          in_ready !== (q.size() != 2) || w_in_ready !== (q.size() != 2))
        begin errors++; $display("FAIL rnd_ctrl c%0d got v %b/%b r %b/%b want count %0d",
                                 c, out_valid, w_out_valid, in_ready, w_in_ready, q.size()); end
      if (flush_i) begin
        q.delete();
      end else begin
        if (out_valid && out_ready && q.size() > 0) begin
          e = q.pop_front();
          checks++;
          if (out_instr !== e.instr || out_pc !== e.pc[31:0] || out_imm !== e.imm32[31:0] ||
              out_fmt !== e.fmt || out_illegal !== e.ill32)
            begin errors++; $display("FAIL rnd32 c%0d got %h %h %h %0d %b want %h %h %h %0d %b", c,
                   out_instr, out_pc, out_imm, out_fmt, out_illegal,
                   e.instr, e.pc[31:0], e.imm32[31:0], e.fmt, e.ill32); end
          checks++;
          if (w_out_instr !== e.instr || w_out_pc !== e.pc || w_out_imm !== e.imm64 ||
              w_out_fmt !== e.fmt || w_out_illegal !== e.ill64)
            begin errors++; $display("FAIL rnd64 c%0d got %h %h %h %0d %b want %h %h %h %0d %b", c,
                   w_out_instr, w_out_pc, w_out_imm, w_out_fmt, w_out_illegal,
                   e.instr, e.pc, e.imm64, e.fmt, e.ill64); end
        end
        if (in_valid && in_ready) begin
          e.instr = in_instr;
          e.pc    = {pc_hi, in_pc};
          ref_decode(in_instr, 32, e.imm32, e.fmt, e.ill32);
          ref_decode(in_instr, 64, e.imm64, e.fmt, e.ill64);
          q.push_back(e);
        end
      end
    end
    @(negedge clk);
    checks++;
    if (q.size() != 0 || out_valid !== 1'b0)
      begin errors++; $display("FAIL rnd_drain got left %0d valid %b want 0 0", q.size(), out_valid); end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'hFFF00093; in_pc = 32'h44;
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1)
      begin errors++; $display("FAIL arst_pre got valid %b want 1", out_valid); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_imm !== 32'h0 || out_fmt !== FMT_NONE ||
        out_illegal !== 1'b0 || out_instr !== 32'h0 || out_pc !== 32'h0 || w_out_valid !== 1'b0)
      begin errors++; $display("FAIL arst got v %b r %b imm %h fmt %0d ill %b instr %h pc %h want reset values",
                               out_valid, in_ready, out_imm, out_fmt, out_illegal, out_instr, out_pc); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_formats();
    test_xlen64();
    test_illegal();
    test_backpressure();
    test_flush();
    test_random_stream(400);
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end

endmodule
